// File: rtl/router_pkg.sv
// Shared encodings for the 1x3 router packet-control logic.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

    localparam logic [1:0] ADDR_P0      = 2'd0;
    localparam logic [1:0] ADDR_P1      = 2'd1;
    localparam logic [1:0] ADDR_P2      = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_if.sv
// Packet-control handshake between the input stage, FIFOs, register stage and router_fsm.
interface router_if;

    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router: decodes headers, sequences FIFO writes and stalls.
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header byte
// LOAD_FIRST_DATA    | writing header byte
// LOAD_DATA          | writing payload bytes
// FIFO_FULL_STATE    | stalled, target FIFO full
// LOAD_AFTER_FULL    | writing the byte held during the stall
// LOAD_PARITY        | writing parity byte
// CHECK_PARITY_ERROR | parity compare in register stage
// WAIT_TILL_EMPTY    | target FIFO still draining previous packet
module router_fsm
    import router_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    router_if.slave  bus
);

    router_state_e state;
    router_state_e state_nxt;
    logic [1:0]    addr_q;
    logic          empty_in;
    logic          empty_addr;
    logic          soft_sel;

    always_comb begin
        empty_in = 1'b0;
        case (bus.data_in)
            ADDR_P0: empty_in = bus.fifo_empty_0;
            ADDR_P1: empty_in = bus.fifo_empty_1;
            ADDR_P2: empty_in = bus.fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
    end

    always_comb begin
        empty_addr = 1'b0;
        soft_sel   = 1'b0;
        case (addr_q)
            ADDR_P0: begin empty_addr = bus.fifo_empty_0; soft_sel = bus.soft_reset_0; end
            ADDR_P1: begin empty_addr = bus.fifo_empty_1; soft_sel = bus.soft_reset_1; end
            ADDR_P2: begin empty_addr = bus.fifo_empty_2; soft_sel = bus.soft_reset_2; end
            default: begin empty_addr = 1'b0;             soft_sel = 1'b0;             end
        endcase
    end

    always_comb begin
        state_nxt = DECODE_ADDRESS;
        if (!soft_sel) begin
            case (state)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && bus.data_in != ADDR_INVALID)
                        state_nxt = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    else
                        state_nxt = DECODE_ADDRESS;
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
                    else                     state_nxt = LOAD_DATA;
                end
                FIFO_FULL_STATE: state_nxt = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
                    else                        state_nxt = LOAD_DATA;
                end
                LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:    state_nxt = empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                default:            state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= ADDR_P0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && bus.pkt_valid)
                addr_q <= bus.data_in;
        end
    end

    // Moore decode straight from the state register; downstream stages expect no extra latency.
    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.busy          = 1'b0;
        case (state)
            DECODE_ADDRESS:  bus.detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                bus.lfd_state     = 1'b1;
                bus.busy          = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                bus.full_state = 1'b1;
                bus.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.busy          = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                bus.busy          = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                bus.rst_int_reg = 1'b1;
                bus.busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: bus.busy = 1'b1;
            default:         bus.detect_add = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed-vector bench for router_fsm; outputs are checked as a packed strobe vector.
module tb_router_fsm;

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] O_DA   = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0101;
    localparam logic [7:0] O_LD   = 8'b0010_0100;
    localparam logic [7:0] O_LAF  = 8'b0001_0101;
    localparam logic [7:0] O_FULL = 8'b0000_1001;
    localparam logic [7:0] O_LP   = 8'b0000_0101;
    localparam logic [7:0] O_CPE  = 8'b0000_0011;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    router_if bus ();

    router_fsm dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        chk(tag, outs(), exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn            = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        cyc("reset", O_DA);
        cyc("reset_hold", O_DA);
        resetn = 1'b1;

        // header to port 1, one payload byte, minimum 5-cycle packet
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        cyc("p1_lfd", O_LFD);
        cyc("p1_ld", O_LD);
        bus.pkt_valid = 1'b0;
        cyc("p1_lp", O_LP);
        cyc("p1_cpe", O_CPE);
        cyc("p1_da", O_DA);

        // port 0 packet with a 4-cycle full stall mid-payload
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        cyc("p0_lfd", O_LFD);
        cyc("p0_ld", O_LD);
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) cyc("p0_full", O_FULL);
        bus.fifo_full = 1'b0;
        cyc("p0_laf", O_LAF);
        cyc("p0_ld_again", O_LD);
        bus.pkt_valid = 1'b0;
        cyc("p0_lp", O_LP);
        cyc("p0_cpe", O_CPE);
        cyc("p0_da", O_DA);

        // port 2 busy: wait keyed on latched address, live data_in ignored
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b0;
        cyc("wte_enter", O_WTE);
        for (int i = 0; i < 6; i++) begin
            bus.data_in = 2'(i % 2);
            cyc("wte_hold", O_WTE);
        end
        bus.fifo_empty_2 = 1'b1;
        cyc("wte_lfd", O_LFD);
        cyc("wte_ld", O_LD);
        bus.pkt_valid = 1'b0;
        cyc("wte_lp", O_LP);
        cyc("wte_cpe", O_CPE);
        cyc("wte_da", O_DA);

        // soft reset: only the addressed port's soft reset matters
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        cyc("sr_lfd", O_LFD);
        cyc("sr_ld", O_LD);
        bus.soft_reset_0 = 1'b1;
        cyc("sr0_ignored", O_LD);
        bus.soft_reset_0 = 1'b0; bus.soft_reset_1 = 1'b1; bus.pkt_valid = 1'b0;
        cyc("sr1_da", O_DA);
        bus.soft_reset_1 = 1'b0;
        cyc("sr_idle", O_DA);

        // invalid address header is dropped
        bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
        cyc("inv_da", O_DA);
        cyc("inv_da2", O_DA);
        bus.pkt_valid = 1'b0;

        // full beats end-of-packet; LAF exits via low_pkt_valid and parity_done; CPE into full
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        cyc("e_lfd", O_LFD);
        bus.pkt_valid = 1'b0;
        cyc("e_ld", O_LD);
        bus.fifo_full = 1'b1;
        cyc("e_full_wins", O_FULL);
        bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1;
        cyc("e_laf", O_LAF);
        cyc("e_low_lp", O_LP);
        bus.low_pkt_valid = 1'b0; bus.fifo_full = 1'b1;
        cyc("e_cpe", O_CPE);
        cyc("e_cpe_full", O_FULL);
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        cyc("e_laf2", O_LAF);
        cyc("e_pd_da", O_DA);
        bus.parity_done = 1'b0;

        // hard reset mid-packet
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
        cyc("r_lfd", O_LFD);
        cyc("r_ld", O_LD);
        resetn = 1'b0;
        cyc("r_reset_da", O_DA);
        resetn = 1'b1; bus.pkt_valid = 1'b0;
        cyc("r_idle", O_DA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
